// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock; done pulses WIDTH+1 cycles after start is accepted.
// start is only honoured in IDLE (ignored while busy or done), so the caller must wait for done before the next issue.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Df,
  output logic             Bo
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH:0]   r_ext;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_nxt;
  logic             d;
  logic             last;

  // One full-subtractor cell, reused on every bit with the borrow fed back through br
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign r_ext  = {d, r};
  assign r_nxt  = r_ext[WIDTH:1];
  assign last   = (cnt == CW'(WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r    <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Df   <= '0;
      Bo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r    <= r_nxt;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          // Results only move on completion so Df/Bo stay stable through SHIFT
          if (last) begin
            Df <= r_nxt;
            Bo <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor at WIDTH 8, 4 and 1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4, start1;
  logic [7:0] A8, B8, Df8;
  logic [3:0] A4, B4, Df4;
  logic [0:0] A1, B1, Df1;
  logic       busy8, done8, Bo8;
  logic       busy4, done4, Bo4;
  logic       busy1, done1, Bo1;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .Df(Df8), .Bo(Bo8));

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4),
    .busy(busy4), .done(done4), .Df(Df4), .Bo(Bo4));

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .busy(busy1), .done(done1), .Df(Df1), .Bo(Bo1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop8(input string tag);
    logic [8:0] e;
    if (q8.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else begin
      e = q8.pop_front();
      chk({tag, "_df"}, {24'd0, Df8}, {24'd0, e[7:0]});
      chk({tag, "_bo"}, {31'd0, Bo8}, {31'd0, e[8]});
    end
  endtask

  // Launch one 8-bit op, check busy length, result hold during SHIFT, and a one-cycle done
  task automatic go8(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] df_prev;
    logic [7:0] dexp;
    int  bc;
    bit  seen;
    bit  hold_bad;
    @(negedge clk);
    A8 = a; B8 = b; start8 = 1'b1;
    dexp = a - b;
    q8.push_back({(a < b), dexp});
    df_prev = Df8;
    @(negedge clk);
    start8 = 1'b0;
    bc = 0; seen = 1'b0; hold_bad = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) bc++;
        if (Df8 !== df_prev) hold_bad = 1'b1;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) pop8(tag);
    chk({tag, "_busy_cycles"}, bc, 32'd8);
    chk({tag, "_df_hold"}, {31'd0, hold_bad}, 32'd0);
    chk({tag, "_busy_in_done"}, {31'd0, busy8}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] e;
    logic [3:0] dexp;
    bit seen;
    @(negedge clk);
    A4 = a; B4 = b; start4 = 1'b1;
    dexp = a - b;
    q4.push_back({(a < b), dexp});
    @(negedge clk);
    start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done4) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("w4_timeout", 32'd0, 32'd1);
    else if (q4.size() == 0) chk("w4_sb_empty", 32'd1, 32'd0);
    else begin
      e = q4.pop_front();
      chk($sformatf("w4_%0h_%0h", a, b), {27'd0, Bo4, Df4}, {27'd0, e});
    end
  endtask

  task automatic go1(input logic a, input logic b, input logic [1:0] exp_bo_df);
    logic [1:0] e;
    bit seen;
    @(negedge clk);
    A1 = a; B1 = b; start1 = 1'b1;
    q1.push_back(exp_bo_df);
    @(negedge clk);
    start1 = 1'b0;
    chk($sformatf("w1_busy_%0b%0b", a, b), {31'd0, busy1}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    if (!seen) chk("w1_timeout", 32'd0, 32'd1);
    else if (q1.size() == 0) chk("w1_sb_empty", 32'd1, 32'd0);
    else begin
      e = q1.pop_front();
      chk($sformatf("w1_%0b%0b", a, b), {30'd0, Bo1, Df1}, {30'd0, e});
    end
  endtask

  initial begin
    int t, nd, d1, d2, cnt;
    logic [1:0] half_tbl [4];
    half_tbl = '{2'b00, 2'b11, 2'b01, 2'b00};

    rst = 1'b1;
    start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    A8 = '0; B8 = '0; A4 = '0; B4 = '0; A1 = '0; B1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_df", {24'd0, Df8}, 32'd0);
    chk("rst_bo", {31'd0, Bo8}, 32'd0);
    chk("rst_w4", {26'd0, busy4, done4, Bo4, Df4}, 32'd0);
    chk("rst_w1", {29'd0, busy1, done1, Bo1, Df1}, 32'd0);

    go8("op5a_3c", 8'h5A, 8'h3C);
    go8("op3c_5a", 8'h3C, 8'h5A);
    go8("op00_01", 8'h00, 8'h01);
    go8("opaa_aa", 8'hAA, 8'hAA);

    // start held high; operands change mid-op and only the second launch may see them
    @(negedge clk);
    A8 = 8'h5A; B8 = 8'h3C; start8 = 1'b1;
    q8.push_back({1'b0, 8'h1E});
    q8.push_back({1'b0, 8'hFF});
    @(negedge clk);
    A8 = 8'hFF; B8 = 8'h00;
    t = 1; nd = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 60 && nd < 2; i++) begin
      @(negedge clk);
      t++;
      if (done8) begin
        nd++;
        pop8(nd == 1 ? "b2b_first" : "b2b_second");
        if (nd == 1) d1 = t;
        else d2 = t;
      end else if (nd == 1 && busy8 && start8) begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("b2b_done_count", nd, 32'd2);
    chk("b2b_interval", d2 - d1, 32'd10);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy8 || done8) cnt++;
    end
    chk("b2b_no_third", cnt, 32'd0);

    // reset in the 4th SHIFT cycle aborts without a done pulse
    @(negedge clk);
    A8 = 8'h80; B8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", {31'd0, busy8}, 32'd1);
    chk("abort_pre_df", {24'd0, Df8}, 32'h0000_00FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_df", {24'd0, Df8}, 32'd0);
    chk("abort_bo", {31'd0, Bo8}, 32'd0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) cnt++;
    end
    chk("abort_no_done", cnt, 32'd0);
    go8("op80_01", 8'h80, 8'h01);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        go4(a[3:0], b[3:0]);

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = i[1:0];
      go1(ab[1], ab[0], half_tbl[i]);
    end

    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
